// File: rtl/bitstream_serializer_pkg.sv
// Shared definitions for the serializer feeding the bitstream pattern detector.
package bspd_pkg;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'b00,
    SER_SHIFT = 2'b01,
    SER_GAP   = 2'b10
  } ser_state_e;

  localparam int DEF_WORD_W = 8;

endpackage

// File: rtl/bitstream_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words on valid/ready and
// shifts them out one bit per clock, with optional idle gap cycles after each word.
module bitstream_serializer
  import bspd_pkg::*;
#(
  parameter int WIDTH     = DEF_WORD_W,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;

  logic last_bit;
  logic accept;
  logic [WIDTH-1:0] shreg_shifted;

  assign last_bit   = (state_q == SER_SHIFT) && (bit_cnt_q == LAST_CNT);
  // With no gap the last-bit cycle doubles as the accept slot, so words run back to back.
  assign data_ready = (state_q == SER_IDLE) || ((GAP == 0) && last_bit);
  assign accept     = data_valid && data_ready;

  assign shreg_shifted = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, shreg_q[WIDTH-1:1]};

  assign bit_valid = (state_q == SER_SHIFT);
  assign bit_out   = bit_valid && ((MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign busy      = (state_q != SER_IDLE);
  assign word_done = last_bit;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      SER_IDLE: begin
        if (accept) begin
          shreg_d   = data_in;
          bit_cnt_d = '0;
          state_d   = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (last_bit) begin
          bit_cnt_d = '0;
          shreg_d   = shreg_shifted;
          if (GAP > 0) begin
            gap_cnt_d = '0;
            state_d   = SER_GAP;
          end else if (accept) begin
            shreg_d = data_in;
          end else begin
            state_d = SER_IDLE;
          end
        end else begin
          shreg_d   = shreg_shifted;
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      SER_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = SER_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SER_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule

// File: doc/bitstream_serializer.md
Name: bitstream_serializer

Overview:
Parallel-in, serial-out stage that sits directly upstream of the serial bitstream pattern detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on bit_out, which drives the detector's bit_in. Optional idle gap cycles between words model framed traffic. It also gives the bench a deterministic bit-accurate stimulus source.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
GAP, 0, number of idle cycles inserted after each word; legal range 0..15.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  WIDTH  parallel word; sampled only on accept.
data_valid  input  1  upstream has a word on data_in.
data_ready  output  1  block can accept a word this cycle (combinational from state/counter).
bit_out  output  1  serial bit to the detector; forced to 0 when bit_valid = 0.
bit_valid  output  1  bit_out carries a real data bit this cycle.
busy  output  1  state is not IDLE.
word_done  output  1  one-cycle pulse, coincident with the last bit of a word.

Behaviour:
- Accept: accept = data_valid && data_ready. On accept, data_in loads the shift register and bit_cnt loads 0. Later changes on data_in have no effect.
- States: IDLE, SHIFT, GAP (encoding in the shared package).
- Reset (reset = 1 at a clock edge) forces:
  - state = IDLE, shift register = 0, bit_cnt = 0, gap_cnt = 0;
  - outputs after that edge: bit_out = 0, bit_valid = 0, busy = 0, word_done = 0, data_ready = 1.
  - Reset has priority over accept.
- IDLE:
  - data_ready = 1, bit_valid = 0.
  - On accept, go to SHIFT.
  - Latency: the first bit appears in the cycle after the accept edge.
- SHIFT:
  - bit_valid = 1.
  - bit_out = shreg[WIDTH-1] when MSB_FIRST = 1, else shreg[0].
  - Each cycle the register shifts toward the output end and bit_cnt increments.
  - The last bit is the cycle with bit_cnt = WIDTH-1; word_done = 1 in that cycle.
  - After the last bit:
    - GAP > 0: go to GAP with gap_cnt = 0.
    - GAP = 0: data_ready = 1 during the last-bit cycle. An accept then reloads and stays in SHIFT, so the next word's first bit follows with no bubble. Without an accept, go to IDLE.
  - data_ready = 0 in every other SHIFT cycle.
- GAP:
  - bit_valid = 0, bit_out = 0, data_ready = 0.
  - Lasts exactly GAP cycles, then goes to IDLE.
  - Minimum spacing between the last bit of one word and the first bit of the next is GAP+1 cycles: the GAP cycles plus the IDLE accept cycle.
- busy = 1 in SHIFT and GAP.
- Counter widths: bit_cnt is $clog2(WIDTH) bits; gap_cnt is 4 bits. Neither counter wraps within a word.
- Reset mid-word: the word is abandoned, no word_done, and the next cycle has bit_valid = 0. The downstream detector sees bit_in = 0 and is reset by the same reset net.
- data_valid while data_ready = 0: ignored, no capture. Upstream must hold data_valid until accepted.
- Idle bits are 0. This is deliberate: the detector has no valid input and must see a stable 0 between words.

Decomposition:
- Package bspd_pkg holds:
  - state encodings SER_IDLE = 2'b00, SER_SHIFT = 2'b01, SER_GAP = 2'b10;
  - shared width constant DEF_WORD_W = 8.
- Single module, no sub-module. The shift register and the two counters are small enough to stay inline.

Test Plan:
- Reset held for 2 cycles, then released with data_valid = 0 → bit_valid = 0, bit_out = 0, data_ready = 1, busy = 0 for 5 cycles.
- WIDTH = 8, MSB_FIRST = 1, accept 8'hB2 at cycle T → bit_out = 1,0,1,1,0,0,1,0 in cycles T+1..T+8, bit_valid = 1 throughout, word_done = 1 only at T+8, then IDLE at T+9.
- GAP = 0, data_valid held with 8'hFF then 8'h00 → 16 contiguous bit_valid cycles: eight 1s then eight 0s. data_ready = 1 at the 8th bit cycle; no bubble between words.
- GAP = 2, two back-to-back words → after the last bit: 2 cycles with bit_valid = 0 and data_ready = 0, 1 IDLE accept cycle, then the next first bit. Last-bit to first-bit spacing = 3 cycles.
- MSB_FIRST = 0, accept 8'h01 → first bit 1, followed by seven 0s; word_done on the 8th bit.
- Accept 8'hF0, assert reset after 3 bits → next cycle bit_valid = 0 and data_ready = 1, word_done never pulses. A fresh 8'hAA is then serialized correctly: 1,0,1,0,1,0,1,0.
